// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting directly in front of a read-only
//   instruction memory. Owns the program counter, presents the word address to
//   memory, captures the returned word into an IF/ID register and offers it to
//   decode through a valid/ready handshake. Taken branches/jumps redirect the
//   PC and flush the in-flight slot; a misaligned redirect target halts fetch
//   with a sticky fault until the next reset.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   imemAddr   out  word address to instruction memory (pc[R+1:2])
//   imemData   in   instruction word returned combinationally for imemAddr
//   redirect   in   load redirectPC this cycle
//   redirectPC in   redirect target byte address
//   outValid   out  instr/pcOut/pcPlus4 hold a valid instruction
//   outReady   in   decode accepts the instruction this cycle
//   instr      out  fetched instruction
//   pcOut      out  byte address of instr
//   pcPlus4    out  pcOut + 4 (wraps modulo 2**32)
//   fault      out  sticky misaligned-redirect flag; fetch halted
//   fetchCount out  instructions handed to decode (saturating)
//   stallCount out  RUN cycles with outValid=1, outReady=0, redirect=0
//
// Build option
//   FETCH_PERF_EN   when defined, fetchCount/stallCount counters are built;
//                   otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int          N        = 32,
   parameter int          R        = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [R-1:0]  imemAddr,
   input  logic [N-1:0]  imemData,
   input  logic          redirect,
   input  logic [31:0]   redirectPC,
   output logic          outValid,
   input  logic          outReady,
   output logic [N-1:0]  instr,
   output logic [31:0]   pcOut,
   output logic [31:0]   pcPlus4,
   output logic          fault,
   output logic [31:0]   fetchCount,
   output logic [31:0]   stallCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  instr_q, instr_d;
   logic [31:0]   pc_out_q, pc_out_d;
   logic [31:0]   pc_plus4_q, pc_plus4_d;
   logic          fault_q, fault_d;

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; a missing default would infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      pc_plus4_d  = pc_plus4_q;
      fault_d     = fault_q;

      unique case (state_q)
         IDLE: state_d = RUN;

         RUN: begin
            if (redirect && (redirectPC[1:0] != 2'b00)) begin
               fault_d     = 1'b1;
               out_valid_d = 1'b0;
               state_d     = HALT;
            end else if (redirect) begin
               // Flush wins over a stall: the held instruction is dropped.
               pc_d        = redirectPC;
               out_valid_d = 1'b0;
            end else if (!out_valid_q || outReady) begin
               instr_d     = imemData;
               pc_out_d    = pc_q;
               pc_plus4_d  = pc_q + 32'd4;
               out_valid_d = 1'b1;
               pc_d        = pc_q + 32'd4;
            end
         end

         HALT: out_valid_d = 1'b0;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         pc_plus4_q  <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         pc_plus4_q  <= pc_plus4_d;
         fault_q     <= fault_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic        transfer;
   logic        stall;

   // A transfer on a redirect edge still counts: decode took the word.
   assign transfer = (state_q == RUN) && out_valid_q && outReady;
   assign stall    = (state_q == RUN) && out_valid_q && !outReady && !redirect;

   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (transfer && (fetch_count_q != 32'hFFFF_FFFF))
         fetch_count_d = fetch_count_q + 32'd1;
      if (stall && (stall_count_q != 32'hFFFF_FFFF))
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetchCount = fetch_count_q;
   assign stallCount = stall_count_q;
`else
   assign fetchCount = 32'd0;
   assign stallCount = 32'd0;
`endif

   assign imemAddr = pc_q[R+1:2];
   assign outValid = out_valid_q;
   assign instr    = instr_q;
   assign pcOut    = pc_out_q;
   assign pcPlus4  = pc_plus4_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit (N=32, R=6, RESET_PC=0). A 64-word memory
//   model answers imemAddr combinationally. Inputs change right after a falling
//   edge and outputs are sampled at the falling edge, half a cycle away from
//   the active rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int N = 32;
   localparam int R = 6;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [R-1:0]  imemAddr;
   logic [N-1:0]  imemData;
   logic          redirect;
   logic [31:0]   redirectPC;
   logic          outValid;
   logic          outReady;
   logic [N-1:0]  instr;
   logic [31:0]   pcOut;
   logic [31:0]   pcPlus4;
   logic          fault;
   logic [31:0]   fetchCount;
   logic [31:0]   stallCount;

   logic [N-1:0]  mem [0:(1<<R)-1];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imemData = mem[imemAddr];

   fetch_unit #(.N(N), .R(R), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imemAddr   (imemAddr),
      .imemData   (imemData),
      .redirect   (redirect),
      .redirectPC (redirectPC),
      .outValid   (outValid),
      .outReady   (outReady),
      .instr      (instr),
      .pcOut      (pcOut),
      .pcPlus4    (pcPlus4),
      .fault      (fault),
      .fetchCount (fetchCount),
      .stallCount (stallCount)
   );

   function automatic logic [31:0] perf(input logic [31:0] v);
      return PERF ? v : 32'd0;
   endfunction

   // Advance one rising edge; returns at the following falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   // Leaves the bench at a falling edge just after rst_n rises.
   task automatic apply_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      outReady   = 1'b1;
      redirect   = 1'b0;
      redirectPC = 32'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Expects a valid instruction with the given address and word.
   task automatic expect_slot(input string name, input logic [31:0] pc_exp,
                              input logic [31:0] word_exp);
      checks++;
      if (outValid !== 1'b1 || pcOut !== pc_exp || instr !== word_exp ||
          pcPlus4 !== pc_exp + 32'd4) begin
         failures++;
         $display("FAIL %s: valid=%b pcOut=%h instr=%h pcPlus4=%h, required valid=1 pcOut=%h instr=%h pcPlus4=%h",
                  name, outValid, pcOut, instr, pcPlus4, pc_exp, word_exp, pc_exp + 32'd4);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      outReady   = 1'b1;
      redirect   = 1'b0;
      redirectPC = 32'd0;
      #1;
      checks++;
      if (outValid !== 1'b0 || instr !== 32'd0 || pcOut !== 32'd0 || pcPlus4 !== 32'd0 ||
          fault !== 1'b0 || fetchCount !== 32'd0 || stallCount !== 32'd0 || imemAddr !== 6'd0) begin
         failures++;
         $display("FAIL reset_values: valid=%b instr=%h pcOut=%h pcPlus4=%h fault=%b fc=%0d sc=%0d addr=%0d, required all zero",
                  outValid, instr, pcOut, pcPlus4, fault, fetchCount, stallCount, imemAddr);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      step();  // edge 1: IDLE -> RUN, no fetch yet
      checks++;
      if (outValid !== 1'b0 || imemAddr !== 6'd0) begin
         failures++;
         $display("FAIL stream_edge1: valid=%b addr=%0d, required valid=0 addr=0", outValid, imemAddr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         expect_slot("stream_slot", 32'(4 * i), mem[i]);
         checks++;
         if (imemAddr !== 6'(i + 1)) begin
            failures++;
            $display("FAIL stream_addr: addr=%0d, required %0d", imemAddr, i + 1);
         end
      end
      checks++;
      if (fetchCount !== perf(32'd3) || stallCount !== 32'd0) begin
         failures++;
         $display("FAIL stream_counts: fc=%0d sc=%0d, required fc=%0d sc=0",
                  fetchCount, stallCount, perf(32'd3));
      end
   endtask

   task automatic test_stall();
      apply_reset();
      step();
      step();
      step();
      step();
      expect_slot("stall_pre", 32'h8, 32'h3333_3333);
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_slot("stall_hold", 32'h8, 32'h3333_3333);
         checks++;
         if (imemAddr !== 6'd3) begin
            failures++;
            $display("FAIL stall_pc_hold: addr=%0d, required 3", imemAddr);
         end
      end
      checks++;
      if (stallCount !== perf(32'd3) || fetchCount !== perf(32'd2)) begin
         failures++;
         $display("FAIL stall_counts: sc=%0d fc=%0d, required sc=%0d fc=%0d",
                  stallCount, fetchCount, perf(32'd3), perf(32'd2));
      end
      outReady = 1'b1;
      step();
      expect_slot("stall_resume", 32'hC, 32'h4444_4444);
      checks++;
      if (fetchCount !== perf(32'd3) || stallCount !== perf(32'd3)) begin
         failures++;
         $display("FAIL resume_counts: fc=%0d sc=%0d, required fc=%0d sc=%0d",
                  fetchCount, stallCount, perf(32'd3), perf(32'd3));
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      step();
      step();
      step();
      step();
      outReady = 1'b0;
      step();  // one stall cycle at pcOut=8
      redirect   = 1'b1;
      redirectPC = 32'h40;
      step();
      checks++;
      if (outValid !== 1'b0 || imemAddr !== 6'd16 || stallCount !== perf(32'd1)) begin
         failures++;
         $display("FAIL redirect_flush: valid=%b addr=%0d sc=%0d, required valid=0 addr=16 sc=%0d",
                  outValid, imemAddr, stallCount, perf(32'd1));
      end
      redirect = 1'b0;
      outReady = 1'b1;
      step();
      expect_slot("redirect_target", 32'h40, mem[16]);
      // Redirect together with outReady: the current word is still counted.
      redirect   = 1'b1;
      redirectPC = 32'h100;
      step();
      checks++;
      if (outValid !== 1'b0 || fetchCount !== perf(32'd3) || imemAddr !== 6'd0) begin
         failures++;
         $display("FAIL redirect_accept: valid=%b fc=%0d addr=%0d, required valid=0 fc=%0d addr=0",
                  outValid, fetchCount, imemAddr, perf(32'd3));
      end
      redirect = 1'b0;
      step();
      expect_slot("alias_fetch", 32'h100, 32'h1111_1111);
   endtask

   task automatic test_wrap();
      redirect   = 1'b1;
      redirectPC = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      step();
      checks++;
      if (outValid !== 1'b1 || pcOut !== 32'hFFFF_FFFC || pcPlus4 !== 32'd0 ||
          instr !== mem[63] || imemAddr !== 6'd0) begin
         failures++;
         $display("FAIL wrap_fetch: valid=%b pcOut=%h pcPlus4=%h instr=%h addr=%0d, required 1 fffffffc 00000000 %h 0",
                  outValid, pcOut, pcPlus4, instr, imemAddr, mem[63]);
      end
      step();
      expect_slot("wrap_next", 32'h0, 32'h1111_1111);
   endtask

   task automatic test_fault();
      // pc is now 4 (imemAddr 1).
      redirect   = 1'b1;
      redirectPC = 32'h42;
      step();
      checks++;
      if (fault !== 1'b1 || outValid !== 1'b0 || imemAddr !== 6'd1) begin
         failures++;
         $display("FAIL fault_set: fault=%b valid=%b addr=%0d, required fault=1 valid=0 addr=1",
                  fault, outValid, imemAddr);
      end
      redirectPC = 32'h40;
      step();
      step();
      redirect = 1'b0;
      step();
      checks++;
      if (fault !== 1'b1 || outValid !== 1'b0 || imemAddr !== 6'd1) begin
         failures++;
         $display("FAIL halt_sticky: fault=%b valid=%b addr=%0d, required fault=1 valid=0 addr=1",
                  fault, outValid, imemAddr);
      end
      // Asynchronous reset mid-cycle must clear everything immediately.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fault !== 1'b0 || outValid !== 1'b0 || imemAddr !== 6'd0 || pcOut !== 32'd0 ||
          fetchCount !== 32'd0 || stallCount !== 32'd0) begin
         failures++;
         $display("FAIL async_reset: fault=%b valid=%b addr=%0d pcOut=%h fc=%0d sc=%0d, required all zero",
                  fault, outValid, imemAddr, pcOut, fetchCount, stallCount);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      expect_slot("restart", 32'h0, 32'h1111_1111);
   endtask

   initial begin
      rst_n      = 1'b0;
      outReady   = 1'b1;
      redirect   = 1'b0;
      redirectPC = 32'd0;
      for (int i = 0; i < (1 << R); i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;
      mem[3] = 32'h4444_4444;

      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_fault();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the word address into the read-only instruction memory, captures the returned word into an IF/ID output register, and hands it to decode with a valid/ready handshake. Accepts branch/jump redirects from later stages, flushing the in-flight instruction, and halts on a misaligned redirect target.

## Interface
Parameters:
- N, 32, instruction width; must equal the instruction memory data width
- R, 6, instruction memory address width in words (memory depth 2**R)
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
- clk  input  1  rising-edge clock, only clock in the block
- rst_n  input  1  reset, asynchronous assert, active-low
- imemAddr  output  R  word address to instruction memory = pc[R+1:2]
- imemData  input  N  instruction word, combinational from memory for imemAddr
- redirect  input  1  1 = load redirectPC this cycle (taken branch/jump)
- redirectPC  input  32  redirect target byte address
- outValid  output  1  instr/pcOut hold a valid instruction
- outReady  input  1  decode accepts the instruction this cycle
- instr  output  N  fetched instruction
- pcOut  output  32  byte address of instr
- pcPlus4  output  32  pcOut + 4 (modulo 2**32)
- fault  output  1  sticky: misaligned redirect target seen; fetch halted
- fetchCount  output  32  instructions handed to decode
- stallCount  output  32  cycles outValid=1 and outReady=0

## Operation
- State machine: IDLE, RUN, HALT.
- IDLE: entered on reset; no fetch; next edge -> RUN unconditionally.
- RUN, priority per edge:
  - redirect=1, redirectPC[1:0]!=0: fault<=1, outValid<=0, -> HALT, pc unchanged.
  - redirect=1, aligned: pc<=redirectPC, outValid<=0 (flush, even if stalled), no capture this edge.
  - else if outValid=0 or outReady=1: instr<=imemData, pcOut<=pc, pcPlus4<=pc+4, outValid<=1, pc<=pc+4.
  - else (outValid=1, outReady=0): hold pc, instr, pcOut, pcPlus4, outValid.
- HALT: outValid=0, pc frozen, redirect ignored; exit only via rst_n.
- Arithmetic: pc is 32 bits, pc+4 wraps 32'hFFFF_FFFC -> 0. Addresses >= 4*2**R alias into memory via pc[R+1:2]; no range check.
- Handshake: transfer occurs on an edge with outValid=1 and outReady=1. Once asserted, outValid and payload stay stable until transfer or redirect/fault.
- imemAddr is always pc[R+1:2], including IDLE and HALT.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, outValid=0, instr=0, pcOut=0, pcPlus4=0, fault=0, fetchCount=0, stallCount=0.
- After rst_n rises: edge 1 IDLE->RUN; edge 2 captures word at RESET_PC, outValid=1 after edge 2.
- Fetch latency: one edge from pc to outValid; sustained throughput one instruction per cycle with outReady held 1.
- Redirect penalty: redirect on edge k -> outValid=0 after k; target instruction valid after edge k+1.
- Redirect and outReady=1 on same edge: current instruction counts as transferred (fetchCount increments); flush still applies to the next slot.
- rst_n asserted mid-stall or mid-redirect: all state returns to reset values immediately.

## Configuration
- FETCH_PERF_EN defined: fetchCount increments on every transfer edge; stallCount increments on every edge in RUN with outValid=1, outReady=0, redirect=0; both saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: counter registers not built; fetchCount and stallCount tied to 0. All other behaviour identical.

## Test plan
- Reset release, memory words 0..3 = 32'h11111111..32'h44444444, outReady=1 -> outValid=1 after edge 2; pcOut 0,4,8,12 with instr 11111111,22222222,33333333,44444444 on consecutive cycles; imemAddr 0,1,2,3,4.
- outReady=0 for 3 cycles while instr at pcOut=8 -> instr/pcOut/pcPlus4 (8/12) held, pc held at 12; stallCount=3 (FETCH_PERF_EN); resumes with pcOut=12 next.
- redirect=1, redirectPC=32'h40 while stalled at pcOut=8 -> outValid=0 next cycle; following cycle pcOut=32'h40, instr = word 16; no fetch of pc 12.
- redirect=1, redirectPC=32'h42 -> fault=1, outValid=0, stays HALT through later aligned redirects; rst_n pulse clears fault, restarts at RESET_PC.
- R=6, pc reaching 32'h100 -> imemAddr=0 (alias); pc=32'hFFFF_FFFC fetch -> pcPlus4=0, next pc=0.
- Build without FETCH_PERF_EN, run first scenario -> fetchCount=stallCount=0 throughout, all other outputs identical.
